// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate of a HI/LO pair, either as one
// 2*WIDTH value (pair_i=1, product) or as two independent WIDTH values.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             pair_i,
  input  logic             neg_hi_i,
  input  logic             neg_lo_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [2*WIDTH-1:0] pair_neg;
  logic [WIDTH-1:0]   hi_neg;
  logic [WIDTH-1:0]   lo_neg;

  always_comb begin
    pair_neg = '0 - {hi_i, lo_i};
    hi_neg   = '0 - hi_i;
    lo_neg   = '0 - lo_i;
    hi_o     = hi_i;
    lo_o     = lo_i;
    if (pair_i) begin
      if (neg_hi_i) begin
        {hi_o, lo_o} = pair_neg;
      end
    end else begin
      if (neg_hi_i) hi_o = hi_neg;
      if (neg_lo_i) lo_o = lo_neg;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO write strobes.
// Define MULDIV_SIGNED_EN to make MULT/DIV signed; otherwise every op is unsigned.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter  int unsigned WIDTH = MD_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic             hi_we,
  output logic             lo_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_zero
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic             is_div_q, is_div_d, neg_hi_q, neg_hi_d, neg_lo_q, neg_lo_d;
  logic [WIDTH-1:0] hi_out_q, hi_out_d, lo_out_q, lo_out_d;
  logic             div_zero_q, div_zero_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic             signed_op, sgn_a, sgn_b, op_is_div, div0;
  logic             sf_pair, sf_neg_hi, sf_neg_lo;
  logic [WIDTH-1:0] sf_hi, sf_lo, sf_hi_o, sf_lo_o;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;

  assign op_is_div = (op_e'(op) == OP_DIV) || (op_e'(op) == OP_DIVU);
`ifdef MULDIV_SIGNED_EN
  assign signed_op = ~op[0];
`else
  assign signed_op = 1'b0;
`endif
  assign sgn_a = signed_op & rs_val[WIDTH-1];
  assign sgn_b = signed_op & rt_val[WIDTH-1];
  assign div0  = op_is_div && (rt_val == '0);

  // One negator serves both ends: operand magnitudes while idle, result signs in FIX.
  always_comb begin
    if (state_q == ST_FIX) begin
      sf_pair   = ~is_div_q;
      sf_neg_hi = neg_hi_q;
      sf_neg_lo = neg_lo_q;
      sf_hi     = hi_q;
      sf_lo     = lo_q;
    end else begin
      sf_pair   = 1'b0;
      sf_neg_hi = sgn_a;
      sf_neg_lo = sgn_b;
      sf_hi     = rs_val;
      sf_lo     = rt_val;
    end
  end

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .pair_i   (sf_pair),
    .neg_hi_i (sf_neg_hi),
    .neg_lo_i (sf_neg_lo),
    .hi_i     (sf_hi),
    .lo_i     (sf_lo),
    .hi_o     (sf_hi_o),
    .lo_o     (sf_lo_o)
  );

  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign div_sh   = {hi_q, lo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, b_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = div0 ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  always_comb begin
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    b_d        = b_q;
    is_div_d   = is_div_q;
    neg_hi_d   = neg_hi_q;
    neg_lo_d   = neg_lo_q;
    hi_out_d   = hi_out_q;
    lo_out_d   = lo_out_q;
    div_zero_d = div_zero_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d      = '0;
          hi_d       = '0;
          lo_d       = op_is_div ? sf_hi_o : sf_lo_o;
          b_d        = op_is_div ? sf_lo_o : sf_hi_o;
          is_div_d   = op_is_div;
          neg_hi_d   = op_is_div ? sgn_a : (sgn_a ^ sgn_b);
          neg_lo_d   = sgn_a ^ sgn_b;
          div_zero_d = div0;
          if (div0) begin
            hi_out_d = rs_val;
            lo_out_d = '1;
          end
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          hi_d = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
      end
      ST_FIX: begin
        hi_out_d = sf_hi_o;
        lo_out_d = sf_lo_o;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      b_q        <= '0;
      is_div_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      hi_out_q   <= '0;
      lo_out_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      b_q        <= b_d;
      is_div_q   <= is_div_d;
      neg_hi_q   <= neg_hi_d;
      neg_lo_q   <= neg_lo_d;
      hi_out_q   <= hi_out_d;
      lo_out_q   <= lo_out_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi_we    = done_q;
  assign lo_we    = done_q;
  assign hi_out   = hi_out_q;
  assign lo_out   = lo_out_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed ops push expected HI/LO, a monitor checks on done.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, done, hi_we, lo_we, div_zero;
  logic [31:0] hi_out, lo_out;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;
  exp_t sb[$];

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .done(done), .hi_we(hi_we), .lo_we(lo_we),
    .hi_out(hi_out), .lo_out(lo_out), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_hi"}, 64'(hi_out), 64'(e.hi));
        check({e.name, "_lo"}, 64'(lo_out), 64'(e.lo));
        check({e.name, "_dz"}, 64'(div_zero), 64'(e.dz));
        check({e.name, "_we"}, 64'({hi_we, lo_we}), 64'b11);
      end
    end
  end

  // Called at a negedge; returns at the negedge of the cycle after done.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int inj_cyc);
    int  lat_exp;
    int  lat;
    int  bad_busy;
    bit  seen;
    lat_exp  = edz ? 1 : 34;
    lat      = 0;
    bad_busy = 0;
    seen     = 1'b0;
    sb.push_back('{nm, ehi, elo, edz});
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    rs_val = $urandom;
    rt_val = $urandom;
    op     = 2'($urandom);
    for (int cyc = 1; cyc <= 100 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == inj_cyc) begin
        start = 1'b1; op = OP_DIVU; rt_val = '0;
      end else begin
        start = 1'b0;
      end
      if (cyc == 1) check({nm, "_dz_c1"}, 64'(div_zero), 64'(edz));
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = cyc;
        check({nm, "_busy_at_done"}, 64'(busy), 64'd0);
      end else if (busy !== 1'b1 && bad_busy == 0) begin
        bad_busy = cyc;
      end
    end
    start = 1'b0;
    check({nm, "_latency"}, 64'(lat), 64'(lat_exp));
    check({nm, "_busy_gap_cycle"}, 64'(bad_busy), 64'd0);
    if (!seen) sb.delete();
    @(negedge clk);
    check({nm, "_after_done"}, 64'({busy, done, hi_we, lo_we}), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; rs_val = '0; rt_val = '0;
    repeat (2) @(negedge clk);
    check("reset_state", {busy, done, hi_we, lo_we, div_zero, hi_out, lo_out}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("multu_ff_x2", OP_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, 1'b0, 0);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0);
`ifdef MULDIV_SIGNED_EN
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    run_op("mult_m3_5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0);
    run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 0);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 0);
`else
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b0, 0);
    run_op("mult_m3_5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'h4, 32'hFFFF_FFF1, 1'b0, 0);
    run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 0);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd7, 32'h0, 1'b0, 0);
`endif
    run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("divu_100_7b", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0);
    run_op("div_s_by_0", OP_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("divu_7_100", OP_DIVU, 32'd7, 32'd100, 32'd7, 32'd0, 1'b0, 0);
    run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
    run_op("multu_3_4_inj", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 10);

    // Abort an op mid-CALC with reset; no result may be written.
    op = OP_MULTU; rs_val = 32'd9; rt_val = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_calc", {busy, done, hi_we, lo_we, div_zero, hi_out, lo_out}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("no_done_after_abort", 64'({hi_out, lo_out}), 64'd0);

    run_op("multu_after_rst", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
